// File: rtl/text_ram_writer.sv
// Character stream to text RAM writer: clears the screen with space glyphs,
// then turns printable bytes into glyph base addresses at a wrapping cursor.
module text_ram_writer #(
    parameter int COLS    = 40,
    parameter int ROWS    = 15,
    parameter int GLYPH_H = 32
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iValid,
    input  logic [7:0]  iChar,
    output logic        oReady,
    output logic        oWe,
    output logic [9:0]  oAddr,
    output logic [11:0] oData,
    output logic [5:0]  oCurCol,
    output logic [3:0]  oCurRow
);

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        WRITE
    } state_t;

    localparam logic [9:0]  CELLS       = 10'(COLS * ROWS);
    localparam logic [5:0]  LAST_COL    = 6'(COLS - 1);
    localparam logic [3:0]  LAST_ROW    = 4'(ROWS - 1);
    localparam logic [11:0] SPACE_GLYPH = 12'('h20 * GLYPH_H);

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    state_t      state, state_nx;
    logic [9:0]  clr_cnt, clr_cnt_nx;
    logic [5:0]  col_nx;
    logic [3:0]  row_nx;
    logic        we_nx;
    logic        ready_nx;
    logic [9:0]  addr_nx;
    logic [11:0] data_nx;

    // Largest cell index is COLS*ROWS-1, which fits the 10-bit address exactly.
    function automatic logic [9:0] cell_addr(input logic [3:0] row, input logic [5:0] col);
        return 10'(row) * 10'(COLS) + 10'(col);
    endfunction

    function automatic logic [11:0] glyph_base(input logic [7:0] code);
        return 12'(code[6:0]) * 12'(GLYPH_H);
    endfunction

    function automatic logic [3:0] next_row(input logic [3:0] row);
        return (row == LAST_ROW) ? 4'd0 : row + 4'd1;
    endfunction

    function automatic logic is_printable(input logic [7:0] code);
        return (code >= 8'h20) && (code <= 8'h7E);
    endfunction

    always_comb begin
        state_nx   = state;
        clr_cnt_nx = clr_cnt;
        col_nx     = oCurCol;
        row_nx     = oCurRow;
        we_nx      = 1'b0;
        addr_nx    = oAddr;
        data_nx    = oData;

        case (state)
            CLEAR: begin
                // clr_cnt reaching CELLS means the last cell went out last cycle.
                if (clr_cnt == CELLS) begin
                    state_nx = IDLE;
                end else begin
                    we_nx      = 1'b1;
                    addr_nx    = clr_cnt;
                    data_nx    = SPACE_GLYPH;
                    clr_cnt_nx = clr_cnt + 10'd1;
                end
            end

            IDLE: begin
                if (iValid) begin
                    if (is_printable(iChar)) begin
                        state_nx = WRITE;
                        we_nx    = 1'b1;
                        addr_nx  = cell_addr(oCurRow, oCurCol);
                        data_nx  = glyph_base(iChar);
                        if (oCurCol == LAST_COL) begin
                            col_nx = 6'd0;
                            row_nx = next_row(oCurRow);
                        end else begin
                            col_nx = oCurCol + 6'd1;
                        end
                    end else begin
                        case (iChar)
                            CH_BS: begin
                                if (oCurCol != 6'd0) begin
                                    state_nx = WRITE;
                                    we_nx    = 1'b1;
                                    col_nx   = oCurCol - 6'd1;
                                    addr_nx  = cell_addr(oCurRow, oCurCol - 6'd1);
                                    data_nx  = SPACE_GLYPH;
                                end
                            end
                            CH_CR: col_nx = 6'd0;
                            CH_LF: begin
                                col_nx = 6'd0;
                                row_nx = next_row(oCurRow);
                            end
                            CH_FF: begin
                                state_nx   = CLEAR;
                                clr_cnt_nx = 10'd0;
                                col_nx     = 6'd0;
                                row_nx     = 4'd0;
                            end
                            default: ;
                        endcase
                    end
                end
            end

            WRITE: state_nx = IDLE;

            default: state_nx = CLEAR;
        endcase

        ready_nx = (state_nx == IDLE);
    end

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            state   <= CLEAR;
            clr_cnt <= 10'd0;
            oWe     <= 1'b0;
            oReady  <= 1'b0;
            oCurCol <= 6'd0;
            oCurRow <= 4'd0;
        end else begin
            state   <= state_nx;
            clr_cnt <= clr_cnt_nx;
            oWe     <= we_nx;
            oReady  <= ready_nx;
            oCurCol <= col_nx;
            oCurRow <= row_nx;
        end
    end

    // Address/data only matter while oWe is high, so they carry no reset.
    always_ff @(posedge iClk) begin
        oAddr <= addr_nx;
        oData <= data_nx;
    end

endmodule

// File: doc/text_ram_writer.md
TEXT_RAM_WRITER -- requirements
Module: text_ram_writer

Interface
REQ-001 SHALL have parameter COLS, default 40, meaning character columns per screen row.
REQ-002 SHALL have parameter ROWS, default 15, meaning character rows per screen.
REQ-003 SHALL have parameter GLYPH_H, default 32, meaning font ROM words per glyph (base address stride).
REQ-004 SHALL have port iClk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port iRst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port iValid  input  1  character byte offered.
REQ-007 SHALL have port iChar  input  8  character code (ASCII).
REQ-008 SHALL have port oReady  output  1  block accepts iChar this cycle.
REQ-009 SHALL have port oWe  output  1  text RAM write strobe.
REQ-010 SHALL have port oAddr  output  10  text RAM cell address, row*COLS+col.
REQ-011 SHALL have port oData  output  12  glyph base address written to the cell.
REQ-012 SHALL have port oCurCol  output  6  current cursor column.
REQ-013 SHALL have port oCurRow  output  4  current cursor row.

Function
REQ-014 SHALL implement FSM states CLEAR, IDLE, WRITE; all outputs registered.
REQ-015 SHALL accept a byte only on a cycle where iValid=1 and oReady=1; oReady SHALL be 1 only in IDLE.
REQ-016 SHALL, in CLEAR, assert oWe every cycle with oAddr stepping 0..COLS*ROWS-1 (0..599) and oData=12'h400 (space glyph), then enter IDLE the cycle after address 599 is written, cursor (0,0).
REQ-017 SHALL, on accepting a printable code 0x20..0x7E, enter WRITE for exactly one cycle with oWe=1, oAddr=oCurRow*COLS+oCurCol, oData={iChar[6:0],5'b0}, then return to IDLE with cursor advanced.
REQ-018 SHALL advance cursor: col+1; col=COLS-1 wraps to col 0, row+1; row=ROWS-1 with row advance wraps to row 0 (no scroll, existing cells kept).
REQ-019 SHALL treat 0x0D (CR) as col=0, row unchanged, no write, remain IDLE.
REQ-020 SHALL treat 0x0A (LF) as col=0, row+1 with same row wrap as REQ-018, no write, remain IDLE.
REQ-021 SHALL treat 0x08 (BS) with col>0 as col-1 then WRITE of 12'h400 at the new cursor, cursor not advanced afterward; with col=0 as no-op.
REQ-022 SHALL treat 0x0C (FF) as entry to CLEAR starting at address 0.
REQ-023 SHALL accept and discard every other code (0x00..0x1F not listed, 0x7F..0xFF) with no write and no cursor change.
REQ-024 SHALL hold oWe=0 in IDLE; oAddr/oData values while oWe=0 are don't-care.
REQ-025 SHALL compute oAddr with no truncation for any cursor within COLS x ROWS; max value 599.
REQ-026 SHALL sustain one printable character per 2 cycles when iValid held high.

Reset
REQ-027 SHALL, when iRst=0 at a rising edge, set state CLEAR, clear counter 0, oWe=0, oReady=0, oCurCol=0, oCurRow=0 on the following cycle.
REQ-028 SHALL begin clearing at address 0 on the first edge with iRst=1; a reset asserted mid-CLEAR or mid-WRITE SHALL abort it and restart per REQ-027.
REQ-029 SHALL ignore iValid/iChar during reset and CLEAR.

Verification
REQ-030 SHALL cover: release reset -> 600 consecutive oWe pulses, addresses 0..599, data 12'h400, then oReady=1 with cursor (0,0).
REQ-031 SHALL cover: send 'A'(0x41) at (0,0) -> one oWe, oAddr=0, oData=12'h820, then cursor (1,0), oReady high again after 1 cycle.
REQ-032 SHALL cover: cursor (39,14), send 'Z'(0x5A) -> oAddr=599, oData=12'hB40, cursor wraps to (0,0).
REQ-033 SHALL cover: cursor (5,3), send 0x08 -> oAddr=124, oData=12'h400, cursor (4,3); then 0x0D -> cursor (0,3); then 0x0A -> cursor (0,4), no oWe for CR/LF.
REQ-034 SHALL cover: send 0x0C at cursor (10,7) -> full 600-cell clear sequence, oReady=0 throughout, cursor (0,0) after.
REQ-035 SHALL cover: drive iRst=0 at clear address 300 -> oWe=0 next cycle, clear restarts at address 0 after release; send 0x07 in IDLE -> accepted, no oWe, cursor unchanged.
